// File: rtl/lc3_pkg.sv
// lc3_pkg: shared LC-3 datapath definitions.
//   WORD_W            - datapath word width
//   RESET_PC_DEFAULT  - default PC loaded on reset
//   IMM*_W            - IR field widths consumed by the sign-extension units
//   fetch_state_e     - fetch/IR stage state encoding
//   word_inc          - modulo-2^16 increment used for PC and IR_PC
package lc3_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 16'h3000;

  localparam int IMM11_W = 11;
  localparam int IMM9_W  = 9;
  localparam int IMM6_W  = 6;
  localparam int IMM5_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  // 16-bit increment; 16'hFFFF wraps naturally to 16'h0000.
  function automatic logic [WORD_W-1:0] word_inc(input logic [WORD_W-1:0] w);
    return w + 16'd1;
  endfunction

endpackage

// File: rtl/lc3_ir_fields.sv
// lc3_ir_fields: pure combinational slicer of the instruction register into
// the immediate/offset fields used by the sign-extension units.
//   ir      in  16  instruction register
//   ir_10_0 out 11  IR[10:0]  (PCoffset11)
//   ir_8_0  out  9  IR[8:0]   (PCoffset9)
//   ir_5_0  out  6  IR[5:0]   (offset6)
//   ir_4_0  out  5  IR[4:0]   (imm5)
module lc3_ir_fields
  import lc3_pkg::*;
(
  input  logic [WORD_W-1:0]  ir,
  output logic [IMM11_W-1:0] ir_10_0,
  output logic [IMM9_W-1:0]  ir_8_0,
  output logic [IMM6_W-1:0]  ir_5_0,
  output logic [IMM5_W-1:0]  ir_4_0
);

  assign ir_10_0 = ir[IMM11_W-1:0];
  assign ir_8_0  = ir[IMM9_W-1:0];
  assign ir_5_0  = ir[IMM6_W-1:0];
  assign ir_4_0  = ir[IMM5_W-1:0];

endmodule

// File: rtl/lc3_fetch_ir.sv
// lc3_fetch_ir: LC-3 instruction fetch + instruction register stage.
// Holds the PC, issues one-word reads (MEM_REQ/MEM_RDY), latches the returned
// word into IR and offers it to decode (IR_VALID/IR_ACK).
// Ports:
//   CLK, RESET (async, active-high)
//   RUN            keep fetching while high
//   PC_LD, PC_IN   redirect (highest priority, returns to IDLE)
//   MEM_REQ/ADDR   registered read request / address
//   MEM_RDY/DATA   read response
//   IR_VALID/ACK   IR handshake toward decode
//   IR, IR_PC      instruction and its address + 1
//   PC             next fetch address
//   FAULT          sticky memory timeout (cleared by PC_LD or reset)
//   IR_10_0..IR_4_0 combinational IR field slices
//   FETCH_COUNT    IR load counter, present only with LC3_FETCH_COUNT_EN
// Parameters: RESET_PC, WAIT_LIMIT (0 disables the memory timeout).
// Optional feature macro: LC3_FETCH_COUNT_EN.
module lc3_fetch_ir
  import lc3_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [15:0]       WAIT_LIMIT = 16'd255
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                RUN,
  input  logic                PC_LD,
  input  logic [WORD_W-1:0]   PC_IN,
  output logic                MEM_REQ,
  output logic [WORD_W-1:0]   MEM_ADDR,
  input  logic                MEM_RDY,
  input  logic [WORD_W-1:0]   MEM_DATA,
  output logic                IR_VALID,
  input  logic                IR_ACK,
  output logic [WORD_W-1:0]   IR,
  output logic [WORD_W-1:0]   IR_PC,
  output logic [WORD_W-1:0]   PC,
  output logic                FAULT,
`ifdef LC3_FETCH_COUNT_EN
  output logic [15:0]         FETCH_COUNT,
`endif
  output logic [IMM11_W-1:0]  IR_10_0,
  output logic [IMM9_W-1:0]   IR_8_0,
  output logic [IMM6_W-1:0]   IR_5_0,
  output logic [IMM5_W-1:0]   IR_4_0
);

  fetch_state_e      state_r, state_nxt_s;
  logic [WORD_W-1:0] pc_r, pc_nxt_s;
  logic              mem_req_r, mem_req_nxt_s;
  logic [WORD_W-1:0] mem_addr_r, mem_addr_nxt_s;
  logic [WORD_W-1:0] ir_r, ir_nxt_s;
  logic [WORD_W-1:0] ir_pc_r, ir_pc_nxt_s;
  logic              ir_valid_r, ir_valid_nxt_s;
  logic              fault_r, fault_nxt_s;
  logic [15:0]       wait_cnt_r, wait_cnt_nxt_s;
  logic              issue_s;

  // Next-state and next-output logic; PC_LD overrides every state.
  always_comb begin
    state_nxt_s    = state_r;
    pc_nxt_s       = pc_r;
    mem_req_nxt_s  = mem_req_r;
    mem_addr_nxt_s = mem_addr_r;
    ir_nxt_s       = ir_r;
    ir_pc_nxt_s    = ir_pc_r;
    ir_valid_nxt_s = ir_valid_r;
    fault_nxt_s    = fault_r;
    wait_cnt_nxt_s = wait_cnt_r;
    issue_s        = 1'b0;

    if (PC_LD) begin
      // Redirect: abandon any outstanding read; a same-cycle MEM_RDY is dropped
      // and IR keeps its stale contents behind IR_VALID=0.
      pc_nxt_s       = PC_IN;
      mem_req_nxt_s  = 1'b0;
      ir_valid_nxt_s = 1'b0;
      fault_nxt_s    = 1'b0;
      state_nxt_s    = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (RUN) begin
            issue_s = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (MEM_RDY) begin
            ir_nxt_s       = MEM_DATA;
            ir_pc_nxt_s    = word_inc(mem_addr_r);
            ir_valid_nxt_s = 1'b1;
            mem_req_nxt_s  = 1'b0;
            state_nxt_s    = ST_VALID;
          end else if ((WAIT_LIMIT != 16'd0) && (word_inc(wait_cnt_r) == WAIT_LIMIT)) begin
            // This is the WAIT_LIMIT-th cycle without a response.
            mem_req_nxt_s = 1'b0;
            fault_nxt_s   = 1'b1;
            state_nxt_s   = ST_FAULT;
          end else begin
            wait_cnt_nxt_s = word_inc(wait_cnt_r);
          end
        end
        ST_VALID: begin
          if (IR_ACK) begin
            ir_valid_nxt_s = 1'b0;
            if (RUN) begin
              issue_s = 1'b1;
            end else begin
              state_nxt_s = ST_IDLE;
            end
          end else begin
            state_nxt_s = ST_VALID;
          end
        end
        ST_FAULT: begin
          state_nxt_s = ST_FAULT;
        end
        default: begin
          state_nxt_s    = ST_IDLE;
          mem_req_nxt_s  = 1'b0;
          ir_valid_nxt_s = 1'b0;
        end
      endcase
    end

    // Common fetch-issue action shared by IDLE and back-to-back VALID.
    if (issue_s) begin
      mem_req_nxt_s  = 1'b1;
      mem_addr_nxt_s = pc_r;
      pc_nxt_s       = word_inc(pc_r);
      wait_cnt_nxt_s = 16'd0;
      state_nxt_s    = ST_WAIT;
    end else begin
      // No fetch this cycle: values chosen above stand.
      wait_cnt_nxt_s = wait_cnt_nxt_s;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r    <= ST_IDLE;
      pc_r       <= RESET_PC;
      mem_req_r  <= 1'b0;
      mem_addr_r <= 16'h0000;
      ir_r       <= 16'h0000;
      ir_pc_r    <= 16'h0000;
      ir_valid_r <= 1'b0;
      fault_r    <= 1'b0;
      wait_cnt_r <= 16'd0;
    end else begin
      state_r    <= state_nxt_s;
      pc_r       <= pc_nxt_s;
      mem_req_r  <= mem_req_nxt_s;
      mem_addr_r <= mem_addr_nxt_s;
      ir_r       <= ir_nxt_s;
      ir_pc_r    <= ir_pc_nxt_s;
      ir_valid_r <= ir_valid_nxt_s;
      fault_r    <= fault_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

`ifdef LC3_FETCH_COUNT_EN
  logic [15:0] fetch_cnt_r;

  // Count accepted IR loads; redirects do not touch the count.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fetch_cnt_r <= 16'd0;
    end else if ((state_r == ST_WAIT) && MEM_RDY && !PC_LD) begin
      fetch_cnt_r <= fetch_cnt_r + 16'd1;
    end else begin
      fetch_cnt_r <= fetch_cnt_r;
    end
  end

  assign FETCH_COUNT = fetch_cnt_r;
`endif

  assign MEM_REQ  = mem_req_r;
  assign MEM_ADDR = mem_addr_r;
  assign IR_VALID = ir_valid_r;
  assign IR       = ir_r;
  assign IR_PC    = ir_pc_r;
  assign PC       = pc_r;
  assign FAULT    = fault_r;

  lc3_ir_fields u_fields (
    .ir      (ir_r),
    .ir_10_0 (IR_10_0),
    .ir_8_0  (IR_8_0),
    .ir_5_0  (IR_5_0),
    .ir_4_0  (IR_4_0)
  );

endmodule

// File: tb/tb_lc3_fetch_ir.sv
// Testbench for lc3_fetch_ir: table-driven vectors, directed corner cases and
// randomized stimulus against a behavioural model. Built with WAIT_LIMIT=4.
module tb_lc3_fetch_ir;

  localparam int LIMIT = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        RUN, PC_LD, MEM_RDY, IR_ACK;
  logic [15:0] PC_IN, MEM_DATA;
  logic        MEM_REQ, IR_VALID, FAULT;
  logic [15:0] MEM_ADDR, IR, IR_PC, PC;
  logic [10:0] IR_10_0;
  logic [8:0]  IR_8_0;
  logic [5:0]  IR_5_0;
  logic [4:0]  IR_4_0;
`ifdef LC3_FETCH_COUNT_EN
  logic [15:0] FETCH_COUNT;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  lc3_fetch_ir #(.RESET_PC(16'h3000), .WAIT_LIMIT(16'd4)) dut (
    .CLK(CLK), .RESET(RESET), .RUN(RUN), .PC_LD(PC_LD), .PC_IN(PC_IN),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_RDY(MEM_RDY), .MEM_DATA(MEM_DATA),
    .IR_VALID(IR_VALID), .IR_ACK(IR_ACK), .IR(IR), .IR_PC(IR_PC), .PC(PC),
    .FAULT(FAULT),
`ifdef LC3_FETCH_COUNT_EN
    .FETCH_COUNT(FETCH_COUNT),
`endif
    .IR_10_0(IR_10_0), .IR_8_0(IR_8_0), .IR_5_0(IR_5_0), .IR_4_0(IR_4_0)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  // Tracks "request outstanding", "instruction held" and "faulted" flags;
  // none of them set means the stage is idle.
  bit          m_req, m_valid, m_fault;
  logic [15:0] m_pc, m_addr, m_ir, m_ir_pc, m_count;
  int          m_waited;

  task automatic model_reset();
    m_req = 0; m_valid = 0; m_fault = 0;
    m_pc = 16'h3000; m_addr = 16'h0; m_ir = 16'h0; m_ir_pc = 16'h0;
    m_count = 16'h0; m_waited = 0;
  endtask

  task automatic model_issue();
    m_req = 1; m_addr = m_pc; m_pc = m_pc + 16'd1; m_waited = 0;
  endtask

  task automatic model_step();
    if (PC_LD) begin
      m_pc = PC_IN; m_req = 0; m_valid = 0; m_fault = 0;
    end else if (m_req) begin
      if (MEM_RDY) begin
        m_ir = MEM_DATA; m_ir_pc = m_addr + 16'd1; m_valid = 1; m_req = 0;
        m_count = m_count + 16'd1;
      end else begin
        m_waited++;
        if (m_waited == LIMIT) begin
          m_req = 0; m_fault = 1;
        end
      end
    end else if (m_valid) begin
      if (IR_ACK) begin
        m_valid = 0;
        if (RUN) model_issue();
      end
    end else if (!m_fault) begin
      if (RUN) model_issue();
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cycle();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_model();
    check("m_req",   {31'd0, MEM_REQ},  {31'd0, m_req});
    check("m_addr",  {16'd0, MEM_ADDR}, {16'd0, m_addr});
    check("m_valid", {31'd0, IR_VALID}, {31'd0, m_valid});
    check("m_ir",    {16'd0, IR},       {16'd0, m_ir});
    check("m_ir_pc", {16'd0, IR_PC},    {16'd0, m_ir_pc});
    check("m_pc",    {16'd0, PC},       {16'd0, m_pc});
    check("m_fault", {31'd0, FAULT},    {31'd0, m_fault});
    check("m_f10",   {21'd0, IR_10_0},  {21'd0, m_ir[10:0]});
    check("m_f8",    {23'd0, IR_8_0},   {23'd0, m_ir[8:0]});
    check("m_f5",    {26'd0, IR_5_0},   {26'd0, m_ir[5:0]});
    check("m_f4",    {27'd0, IR_4_0},   {27'd0, m_ir[4:0]});
`ifdef LC3_FETCH_COUNT_EN
    check("m_count", {16'd0, FETCH_COUNT}, {16'd0, m_count});
`endif
  endtask

  task automatic set_in(input logic run, input logic ld, input logic [15:0] pin,
                        input logic rdy, input logic [15:0] data, input logic ack);
    RUN = run; PC_LD = ld; PC_IN = pin; MEM_RDY = rdy; MEM_DATA = data; IR_ACK = ack;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  typedef struct {
    logic run, pc_ld; logic [15:0] pc_in; logic rdy; logic [15:0] data; logic ack;
    logic req; logic [15:0] addr; logic valid; logic [15:0] ir, ir_pc, pc; logic fault;
  } vec_t;

  vec_t vecs [15];

  initial begin
    // inputs: run, pc_ld, pc_in, rdy, data, ack | expected: req, addr, valid, ir, ir_pc, pc, fault
    vecs[0]  = '{1'b1,1'b0,16'h0,1'b0,16'h0,1'b0,     1'b1,16'h3000,1'b0,16'h0000,16'h0000,16'h3001,1'b0};
    vecs[1]  = '{1'b1,1'b0,16'h0,1'b0,16'h0,1'b0,     1'b1,16'h3000,1'b0,16'h0000,16'h0000,16'h3001,1'b0};
    vecs[2]  = '{1'b1,1'b0,16'h0,1'b0,16'h0,1'b0,     1'b1,16'h3000,1'b0,16'h0000,16'h0000,16'h3001,1'b0};
    vecs[3]  = '{1'b1,1'b0,16'h0,1'b1,16'h1261,1'b0,  1'b0,16'h3000,1'b1,16'h1261,16'h3001,16'h3001,1'b0};
    vecs[4]  = '{1'b1,1'b0,16'h0,1'b0,16'h0,1'b0,     1'b0,16'h3000,1'b1,16'h1261,16'h3001,16'h3001,1'b0};
    vecs[5]  = '{1'b1,1'b0,16'h0,1'b0,16'h0,1'b1,     1'b1,16'h3001,1'b0,16'h1261,16'h3001,16'h3002,1'b0};
    vecs[6]  = '{1'b1,1'b0,16'h0,1'b1,16'h5020,1'b1,  1'b0,16'h3001,1'b1,16'h5020,16'h3002,16'h3002,1'b0};
    vecs[7]  = '{1'b1,1'b0,16'h0,1'b1,16'h5020,1'b1,  1'b1,16'h3002,1'b0,16'h5020,16'h3002,16'h3003,1'b0};
    vecs[8]  = '{1'b1,1'b0,16'h0,1'b1,16'h6A3F,1'b1,  1'b0,16'h3002,1'b1,16'h6A3F,16'h3003,16'h3003,1'b0};
    vecs[9]  = '{1'b0,1'b0,16'h0,1'b0,16'h0,1'b1,     1'b0,16'h3002,1'b0,16'h6A3F,16'h3003,16'h3003,1'b0};
    vecs[10] = '{1'b0,1'b0,16'h0,1'b0,16'h0,1'b0,     1'b0,16'h3002,1'b0,16'h6A3F,16'h3003,16'h3003,1'b0};
    vecs[11] = '{1'b1,1'b0,16'h0,1'b0,16'h0,1'b0,     1'b1,16'h3003,1'b0,16'h6A3F,16'h3003,16'h3004,1'b0};
    vecs[12] = '{1'b1,1'b1,16'h4000,1'b1,16'hDEAD,1'b0,1'b0,16'h3003,1'b0,16'h6A3F,16'h3003,16'h4000,1'b0};
    vecs[13] = '{1'b1,1'b0,16'h0,1'b0,16'h0,1'b0,     1'b1,16'h4000,1'b0,16'h6A3F,16'h3003,16'h4001,1'b0};
    vecs[14] = '{1'b1,1'b0,16'h0,1'b1,16'h0ABC,1'b0,  1'b0,16'h4000,1'b1,16'h0ABC,16'h4001,16'h4001,1'b0};

    set_in(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    do_reset();

    // Reset state.
    check("rst_req",   {31'd0, MEM_REQ},  32'd0);
    check("rst_addr",  {16'd0, MEM_ADDR}, 32'h0);
    check("rst_pc",    {16'd0, PC},       32'h3000);
    check("rst_ir",    {16'd0, IR},       32'h0);
    check("rst_valid", {31'd0, IR_VALID}, 32'd0);

    // Table: single fetch, back-to-back, idle, redirect racing MEM_RDY.
    for (int i = 0; i < 15; i++) begin
      set_in(vecs[i].run, vecs[i].pc_ld, vecs[i].pc_in, vecs[i].rdy, vecs[i].data, vecs[i].ack);
      cycle();
      check($sformatf("vec%0d_req", i),   {31'd0, MEM_REQ},  {31'd0, vecs[i].req});
      check($sformatf("vec%0d_addr", i),  {16'd0, MEM_ADDR}, {16'd0, vecs[i].addr});
      check($sformatf("vec%0d_valid", i), {31'd0, IR_VALID}, {31'd0, vecs[i].valid});
      check($sformatf("vec%0d_ir", i),    {16'd0, IR},       {16'd0, vecs[i].ir});
      check($sformatf("vec%0d_ir_pc", i), {16'd0, IR_PC},    {16'd0, vecs[i].ir_pc});
      check($sformatf("vec%0d_pc", i),    {16'd0, PC},       {16'd0, vecs[i].pc});
      check($sformatf("vec%0d_fault", i), {31'd0, FAULT},    {31'd0, vecs[i].fault});
      if (i == 3) begin
        check("fetch_ir_5_0",  {26'd0, IR_5_0},  32'h21);
        check("fetch_ir_10_0", {21'd0, IR_10_0}, 32'h261);
      end
    end
    check("ir_4_0_0abc", {27'd0, IR_4_0}, 32'h1C);
    check("ir_8_0_0abc", {23'd0, IR_8_0}, 32'hBC);

    // Asynchronous reset in the middle of a WAIT.
    set_in(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    cycle();
    check("prerst_req", {31'd0, MEM_REQ}, 32'd1);
    #2 RESET = 1'b1;
    model_reset();
    #1;
    check("arst_req",   {31'd0, MEM_REQ},  32'd0);
    check("arst_valid", {31'd0, IR_VALID}, 32'd0);
    check("arst_pc",    {16'd0, PC},       32'h3000);
    check("arst_fault", {31'd0, FAULT},    32'd0);
    check("arst_ir4",   {27'd0, IR_4_0},   32'd0);
    set_in(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    @(negedge CLK);
    RESET = 1'b0;

    // PC wrap at 16'hFFFF.
    set_in(1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0, 1'b0);
    cycle();
    set_in(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    cycle();
    check("wrap_addr", {16'd0, MEM_ADDR}, 32'hFFFF);
    check("wrap_pc",   {16'd0, PC},       32'h0000);
    set_in(1'b1, 1'b0, 16'h0, 1'b1, 16'h0F0F, 1'b0);
    cycle();
    check("wrap_ir_pc", {16'd0, IR_PC}, 32'h0000);
    set_in(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    cycle();

    // Timeout after LIMIT WAIT cycles, sticky, cleared by PC_LD.
    set_in(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    cycle();
    for (int k = 1; k < LIMIT; k++) begin
      cycle();
      check($sformatf("to_wait%0d_fault", k), {31'd0, FAULT},   32'd0);
      check($sformatf("to_wait%0d_req", k),   {31'd0, MEM_REQ}, 32'd1);
    end
    cycle();
    check("to_fault",     {31'd0, FAULT},   32'd1);
    check("to_req_drop",  {31'd0, MEM_REQ}, 32'd0);
    set_in(1'b1, 1'b0, 16'h0, 1'b1, 16'h1234, 1'b1);
    cycle();
    cycle();
    check("to_sticky",    {31'd0, FAULT},    32'd1);
    check("to_sticky_rq", {31'd0, MEM_REQ},  32'd0);
    check("to_sticky_v",  {31'd0, IR_VALID}, 32'd0);
    set_in(1'b0, 1'b1, 16'h5000, 1'b0, 16'h0, 1'b0);
    cycle();
    check("to_clear", {31'd0, FAULT}, 32'd0);
    check("to_pc",    {16'd0, PC},    32'h5000);

    // Three completed fetches from reset.
    set_in(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
      cycle();
      set_in(1'b1, 1'b0, 16'h0, 1'b1, 16'h2000 + 16'(k), 1'b0);
      cycle();
      set_in(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
      cycle();
    end
    check("cnt3_ir_pc", {16'd0, IR_PC}, 32'h3003);
`ifdef LC3_FETCH_COUNT_EN
    check("fetch_count3", {16'd0, FETCH_COUNT}, 32'd3);
`endif

    // Randomized traffic against the behavioural model.
    for (int n = 0; n < 600; n++) begin
      set_in(($urandom_range(0, 7) != 0),
             ($urandom_range(0, 19) == 0),
             16'($urandom),
             ($urandom_range(0, 1) == 1),
             16'($urandom),
             ($urandom_range(0, 4) < 3));
      cycle();
      check_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_fetch_ir.md
Name: lc3_fetch_ir

Overview:
- Instruction-fetch and instruction-register stage of the LC-3 datapath.
- Holds the PC and issues one-word reads to instruction memory over a request/ready handshake.
- Latches the returned word into IR and presents it to decode under a valid/ack handshake.
- Drives the IR bit-fields consumed directly by the downstream sign-extension units (IR[10:0], IR[8:0], IR[5:0], IR[4:0]).

Parameters:
- RESET_PC, 16'h3000, PC value loaded on reset.
- WAIT_LIMIT, 255, WAIT-state cycles without MEM_RDY before entering FAULT; 0 disables the timeout.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- RUN  in  1  level; 1 = keep fetching.
- PC_LD  in  1  redirect strobe (branch/JSR/TRAP).
- PC_IN  in  16  redirect target.
- MEM_REQ  out  1  read request, registered.
- MEM_ADDR  out  16  read address, registered.
- MEM_RDY  in  1  read data valid.
- MEM_DATA  in  16  read data.
- IR_VALID  out  1  IR holds an unconsumed instruction.
- IR_ACK  in  1  decode consumed IR.
- IR  out  16  instruction register.
- IR_PC  out  16  address of the instruction in IR, plus 1 (the incremented PC).
- PC  out  16  next fetch address.
- FAULT  out  1  memory timeout, sticky.
- IR_10_0  out  11  IR[10:0].
- IR_8_0  out  9  IR[8:0].
- IR_5_0  out  6  IR[5:0].
- IR_4_0  out  5  IR[4:0].

Behaviour:
- Reset (asynchronous, RESET=1):
  - state=IDLE, PC=RESET_PC.
  - MEM_REQ=0, MEM_ADDR=0, IR=0, IR_PC=0, IR_VALID=0, FAULT=0.
  - Wait counter=0. All field outputs are therefore 0.
- States: IDLE, WAIT, VALID, FAULT.
- Fetch issue (any transition into WAIT):
  - MEM_REQ<=1, MEM_ADDR<=PC, PC<=PC+1 (mod 2^16; 16'hFFFF wraps to 16'h0000), wait counter<=0.
- IDLE: RUN=1 -> issue fetch, go to WAIT.
- WAIT:
  - MEM_REQ and MEM_ADDR are held until MEM_RDY=1 is sampled.
  - On MEM_RDY=1: IR<=MEM_DATA, IR_PC<=MEM_ADDR+1, IR_VALID<=1, MEM_REQ<=0, go to VALID.
  - Without MEM_RDY: counter increments. When the counter reaches WAIT_LIMIT (WAIT_LIMIT!=0): MEM_REQ<=0, FAULT<=1, go to FAULT.
- VALID:
  - IR, IR_PC and the field outputs are stable.
  - On IR_ACK=1: IR_VALID<=0. With RUN=1, issue the next fetch the same edge (back-to-back, no idle cycle); with RUN=0, go to IDLE.
- FAULT: hold. Exit only by reset or PC_LD.
- PC_LD=1 has highest priority, in any state:
  - PC<=PC_IN, MEM_REQ<=0, IR_VALID<=0, FAULT<=0, go to IDLE.
  - Any MEM_RDY that same cycle is ignored.
  - PC_LD together with IR_ACK: the load wins and the instruction is discarded.
  - IR keeps its old value; IR_VALID=0 marks it stale.
- MEM_RDY while MEM_REQ=0 is ignored (late response to an aborted request).
- Latency:
  - RUN rise in IDLE -> MEM_REQ high next edge.
  - MEM_RDY sampled -> IR_VALID high next edge.
  - Minimum RUN-to-IR_VALID is 2 cycles.
  - Back-to-back throughput is 1 instruction per 2 cycles with zero-wait memory.
- Field outputs are combinational slices of the IR register only and never glitch except on an IR load.

Optional Feature:
- Macro LC3_FETCH_COUNT_EN.
- When defined: adds output FETCH_COUNT (16 bits). It resets to 0, increments by 1 on every IR load (MEM_RDY accepted in WAIT), wraps 16'hFFFF to 0, and is unaffected by PC_LD.
- When undefined: port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package lc3_pkg:
  - WORD_W=16.
  - Default RESET_PC=16'h3000.
  - Fetch state enum {IDLE, WAIT, VALID, FAULT}.
  - Field width constants 11/9/6/5, shared with the sign-extension units.
- One natural sub-module: lc3_ir_fields, a pure slicer from the 16-bit IR to IR_10_0/IR_8_0/IR_5_0/IR_4_0, reusable by decode.

Test Plan:
- Reset: assert RESET mid-WAIT with MEM_REQ=1 -> immediately MEM_REQ=0, IR_VALID=0, PC=16'h3000, FAULT=0, IR_4_0=0.
- Single fetch: RUN=1, MEM_RDY 3 cycles after MEM_REQ with MEM_DATA=16'h1261 -> MEM_ADDR=16'h3000, IR=16'h1261, IR_PC=16'h3001, PC=16'h3001, IR_5_0=6'h21, IR_10_0=11'h261.
- Back-to-back: zero-wait memory, IR_ACK held 1 -> MEM_ADDR sequence 3000, 3001, 3002, with IR_VALID every other cycle.
- Wrap: PC_LD with PC_IN=16'hFFFF, then fetch -> MEM_ADDR=16'hFFFF, IR_PC=16'h0000, PC=16'h0000.
- Redirect: PC_LD=1 with PC_IN=16'h4000 in the same cycle as MEM_RDY=1 -> IR unchanged, IR_VALID=0, next MEM_ADDR=16'h4000.
- Timeout: WAIT_LIMIT=4, MEM_RDY never asserted -> FAULT=1 and MEM_REQ=0 after 4 WAIT cycles; PC_LD clears FAULT. With LC3_FETCH_COUNT_EN, 3 completed fetches -> FETCH_COUNT=3.
